mult2_seq_ctrl: RTL and testbench



---
 rtl/mult2_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mult2_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mult2_seq_ctrl.sv
// Sequential N x N unsigned multiplier that time-shares one external 2x2 core, one digit pair per clock.
// Optional build macro ZERO_SKIP_EN: a zero operand finishes straight away with product 0 and no RUN phase.
module mult2_seq_ctrl #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic [1:0]     m_a,
   output logic [1:0]     m_b,
   input  logic [3:0]     m_p,
   output logic [1:0]     dbg_state
);

   localparam int D    = N / 2;
   localparam int IW   = $clog2(D);
   localparam int KW   = 2 * IW;
   localparam int SW   = $clog2(2 * N);
   localparam int KMAX = D * D - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: start is taken on a rising edge only while ready=1; done is a
   // single-cycle pulse and product is valid from that cycle until the next accept.
   state_t         state_q;
   logic [N-1:0]   a_q, b_q;
   logic [2*N-1:0] acc_q, product_q;
   logic [KW-1:0]  k_q;
   logic           ready_q, busy_q, done_q;
   logic [1:0]     m_a_q, m_b_q;

   logic [KW-1:0]  k_d;
   logic [2*N-1:0] acc_d, term;
   logic [SW-1:0]  shamt;
   logic [1:0]     m_a_d, m_b_d;
   logic           zero_op;
   logic           last_k;

`ifdef ZERO_SKIP_EN
   assign zero_op = (a == '0) || (b == '0);
`else
   assign zero_op = 1'b0;
`endif

   assign last_k = (k_q == KW'(KMAX));

   // Low index bits select the a digit, high bits the b digit; the core digits
   // for step k+1 are registered on the edge that retires step k.
   always_comb begin
      k_d   = k_q + KW'(1);
      shamt = SW'({k_q[IW-1:0], 1'b0}) + SW'({k_q[KW-1:IW], 1'b0});
      term  = {{(2*N-4){1'b0}}, m_p} << shamt;
      acc_d = acc_q + term;
      m_a_d = a_q[2*k_d[IW-1:0] +: 2];
      m_b_d = b_q[2*k_d[KW-1:IW] +: 2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         k_q       <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         m_a_q     <= '0;
         m_b_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && zero_op) begin
                  product_q <= '0;
                  ready_q   <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  acc_q   <= '0;
                  k_q     <= '0;
                  m_a_q   <= a[1:0];
                  m_b_q   <= b[1:0];
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               k_q   <= k_d;
               if (last_k) begin
                  product_q <= acc_d;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  m_a_q     <= '0;
                  m_b_q     <= '0;
                  state_q   <= S_DONE;
               end else begin
                  m_a_q <= m_a_d;
                  m_b_q <= m_b_d;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               m_a_q   <= '0;
               m_b_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign product   = product_q;
   assign m_a       = m_a_q;
   assign m_b       = m_b_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mult2_seq_ctrl.sv
// Self-checking bench for mult2_seq_ctrl (N=8) with a behavioural 2x2 core model.
module tb_mult2_seq_ctrl;

   localparam int N = 8;
   localparam int D = N / 2;
   localparam int W = 2 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         ready, busy, done;
   logic [W-1:0] product;
   logic [1:0]   m_a, m_b, dbg_state;
   logic [3:0]   m_p;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   mult2_seq_ctrl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .product(product),
      .m_a(m_a), .m_b(m_b), .m_p(m_p), .dbg_state(dbg_state)
   );

   assign m_p = {2'b00, m_a} * {2'b00, m_b};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   // Called on a falling edge; returns on the falling edge of the ready cycle.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input bit hold);
      logic [W-1:0] prev;
      int c, k, i, j, busy_cnt, done_cyc, dig_err, stab_err, exp_busy;
      bit zs;
      zs = 1'b0;
`ifdef ZERO_SKIP_EN
      zs = (ta == '0) || (tb_v == '0);
`endif
      exp_busy = zs ? 0 : D * D;
      prev  = product;
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      exp_q.push_back(W'(ta) * W'(tb_v));
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         a = N'(8'h12);
         b = N'(8'h34);
      end else begin
         start = 1'b0;
      end
      c = 1; busy_cnt = 0; done_cyc = 0; dig_err = 0; stab_err = 0;
      while (done_cyc == 0 && c < 200) begin
         if (busy) begin
            k = c - 1;
            i = k % D;
            j = k / D;
            if (m_a !== ta[2*i +: 2] || m_b !== tb_v[2*j +: 2]) dig_err++;
            busy_cnt++;
         end
         if (!done && product !== prev) stab_err++;
         if (done) done_cyc = c;
         else begin
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      check("done_seen", done_cyc != 0, 1);
      check("busy_cycles", busy_cnt, exp_busy);
      check("done_cycle", done_cyc, exp_busy + 1);
      check("digit_seq", dig_err, 0);
      check("product_stable", stab_err, 0);
      check("busy_at_done", busy, 0);
      check("ready_at_done", ready, 0);
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else check("product", product, exp_q.pop_front());
      @(negedge clk);
      check("ready_after", ready, 1);
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      int seen;
      logic [N-1:0] ra, rb;
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      check("rst_m_a", m_a, 0);
      check("rst_m_b", m_b, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(8'hFF, 8'hFF, 1'b0);
      run_op(8'h0D, 8'h0B, 1'b0);
      run_op(8'h03, 8'h05, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("hold_product", product, 16'h000F);
         check("hold_idle", ready, 1);
      end

      // Abort a run at its eighth cycle with an asynchronous reset.
      start = 1'b1; a = 8'hAA; b = 8'h55;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_product", product, 0);
      check("abort_m_a", m_a, 0);
      check("abort_m_b", m_b, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort_no_done", seen, 0);
      run_op(8'h02, 8'h03, 1'b0);

      run_op(8'h00, 8'h7F, 1'b0);
      run_op(8'h7F, 8'h00, 1'b0);
      run_op(8'h80, 8'h01, 1'b0);
      for (int n = 0; n < 6; n++) begin
         ra = N'($urandom_range(0, 255));
         rb = N'($urandom_range(0, 255));
         run_op(ra, rb, 1'b0);
      end
      check("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
